// File: rtl/write_scoreboard_pkg.sv
// Shared types for the write scoreboard: operand-forward select encodings
// and the per-stage slot record tracked for X, M and W.
package write_scoreboard_pkg;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_XM   = 2'b01,
        FWD_MW   = 2'b10,
        FWD_LONG = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/write_scoreboard_match.sv
// Per-source-operand comparator: picks the forward source and flags
// load-use and outstanding mult/div hazards for one register specifier.
module scoreboard_match
    import write_scoreboard_pkg::*;
(
    input  logic [4:0] src,
    input  logic       x_valid,
    input  logic [4:0] x_rd,
    input  logic       x_load,
    input  logic       m_valid,
    input  logic [4:0] m_rd,
    input  logic       wb_long_valid,
    input  logic [4:0] wb_long_rd,
    input  logic       long_busy,
    input  logic [4:0] pending_rd,
    output logic [1:0] sel,
    output logic       load_use,
    output logic       long_hit
);

    logic src_nz;
    assign src_nz = (src != 5'd0);

    // Youngest producer wins; the long bus is newest since it bypasses all slots.
    always_comb begin
        sel = FWD_RF;
        if (src_nz) begin
            if (wb_long_valid && (wb_long_rd == src))
                sel = FWD_LONG;
            else if (x_valid && (x_rd == src))
                sel = FWD_XM;
            else if (m_valid && (m_rd == src))
                sel = FWD_MW;
        end
    end

    assign load_use = src_nz & x_valid & x_load & (x_rd == src);
    assign long_hit = src_nz & long_busy & (pending_rd == src);

endmodule

// File: rtl/write_scoreboard.sv
// In-order issue scoreboard: tracks X/M/W destinations and one outstanding
// mult/div, producing the D-stage stall and operand forward selects.
module write_scoreboard
    import write_scoreboard_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       issue_valid,
    input  logic [4:0] issue_rd,
    input  logic       issue_we,
    input  logic       issue_load,
    input  logic       issue_long,
    input  logic [4:0] query_rs,
    input  logic [4:0] query_rt,
    input  logic       wb_long_valid,
    input  logic [4:0] wb_long_rd,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       long_busy
);

    slot_t      x_q, m_q, w_q;
    logic       busy_q;
    logic [4:0] pending_q;

    logic [1:0] rs_sel, rt_sel;
    logic       rs_lu, rt_lu, rs_long, rt_long;
    logic       long_clear, waw, hazard, accept, rd_nz;

    scoreboard_match u_match_rs (
        .src           (query_rs),
        .x_valid       (x_q.valid),
        .x_rd          (x_q.rd),
        .x_load        (x_q.load),
        .m_valid       (m_q.valid),
        .m_rd          (m_q.rd),
        .wb_long_valid (wb_long_valid),
        .wb_long_rd    (wb_long_rd),
        .long_busy     (busy_q),
        .pending_rd    (pending_q),
        .sel           (rs_sel),
        .load_use      (rs_lu),
        .long_hit      (rs_long)
    );

    scoreboard_match u_match_rt (
        .src           (query_rt),
        .x_valid       (x_q.valid),
        .x_rd          (x_q.rd),
        .x_load        (x_q.load),
        .m_valid       (m_q.valid),
        .m_rd          (m_q.rd),
        .wb_long_valid (wb_long_valid),
        .wb_long_rd    (wb_long_rd),
        .long_busy     (busy_q),
        .pending_rd    (pending_q),
        .sel           (rt_sel),
        .load_use      (rt_lu),
        .long_hit      (rt_long)
    );

    assign rd_nz      = (issue_rd != 5'd0);
    assign long_clear = busy_q & wb_long_valid & (wb_long_rd == pending_q);
    assign waw        = busy_q & (pending_q == issue_rd);

    // A result landing on the long bus this cycle resolves RAW/WAW and frees the unit.
    assign hazard = rs_lu | rt_lu
                  | ((rs_long | rt_long | waw) & ~long_clear)
                  | (issue_long & busy_q & ~long_clear);

    // Gate with reset so outputs are quiet even while wb/issue inputs toggle in reset.
    assign stall      = reset_n & issue_valid & hazard;
    assign fwd_rs_sel = reset_n ? rs_sel : FWD_RF;
    assign fwd_rt_sel = reset_n ? rt_sel : FWD_RF;
    assign long_busy  = busy_q;

    assign accept = issue_valid & ~stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= SLOT_EMPTY;
            m_q <= SLOT_EMPTY;
            w_q <= SLOT_EMPTY;
        end else begin
            w_q <= m_q;
            m_q <= x_q;
            if (accept) begin
                x_q.valid <= issue_we & ~issue_long & rd_nz;
                x_q.rd    <= issue_rd;
                x_q.load  <= issue_load;
            end else begin
                x_q <= SLOT_EMPTY;
            end
        end
    end

    // Set has priority over clear so a back-to-back mult/div keeps the unit busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q    <= 1'b0;
            pending_q <= 5'd0;
        end else if (accept & issue_long & issue_we & rd_nz) begin
            busy_q    <= 1'b1;
            pending_q <= issue_rd;
        end else if (long_clear) begin
            busy_q    <= 1'b0;
        end
    end

    // W is tracked for pipeline bookkeeping only; the regfile is write-first so it never forwards.
    logic unused_ok;
    assign unused_ok = ^{w_q, m_q.load};

endmodule

// File: tb/tb_write_scoreboard.sv
// Directed bench for write_scoreboard: forwarding, load-use, mult/div
// hazards, r0 handling and asynchronous reset.
module tb_write_scoreboard;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       issue_valid, issue_we, issue_load, issue_long;
    logic [4:0] issue_rd, query_rs, query_rt, wb_long_rd;
    logic       wb_long_valid;
    logic       stall, long_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int checks = 0;
    int errors = 0;

    write_scoreboard dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_we      (issue_we),
        .issue_load    (issue_load),
        .issue_long    (issue_long),
        .query_rs      (query_rs),
        .query_rt      (query_rt),
        .wb_long_valid (wb_long_valid),
        .wb_long_rd    (wb_long_rd),
        .stall         (stall),
        .fwd_rs_sel    (fwd_rs_sel),
        .fwd_rt_sel    (fwd_rt_sel),
        .long_busy     (long_busy)
    );

    always #5 clock = ~clock;

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_we = 0; issue_load = 0; issue_long = 0;
        query_rs = 0; query_rt = 0; wb_long_valid = 0; wb_long_rd = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic we, input logic ld, input logic lg);
        issue_valid = 1; issue_rd = rd; issue_we = we; issue_load = ld; issue_long = lg;
    endtask

    // Inputs change 1ns after the rising edge; checks follow 1ns later, far from the next edge.
    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        issue(5'd4, 1, 0, 1);
        query_rs = 5'd6; query_rt = 5'd6; wb_long_valid = 1; wb_long_rd = 5'd6;
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        checks++; if (fwd_rs_sel !== 2'b00) begin errors++; $display("FAIL reset_rs_sel got=%b exp=00", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== 2'b00) begin errors++; $display("FAIL reset_rt_sel got=%b exp=00", fwd_rt_sel); end
        checks++; if (long_busy !== 1'b0) begin errors++; $display("FAIL reset_long_busy got=%0b exp=0", long_busy); end
        tick(); tick();
        idle();
        reset_n = 1;
        tick();
    endtask

    task automatic test_forward();
        idle(); issue(5'd5, 1, 0, 0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_issue_stall got=%0b exp=0", stall); end
        tick();
        idle(); issue(5'd0, 0, 0, 0); query_rs = 5'd5;
        #1;
        checks++; if (fwd_rs_sel !== 2'b01) begin errors++; $display("FAIL fwd_xm got=%b exp=01", fwd_rs_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_xm_stall got=%0b exp=0", stall); end
        tick();
        #1;
        checks++; if (fwd_rs_sel !== 2'b10) begin errors++; $display("FAIL fwd_mw got=%b exp=10", fwd_rs_sel); end
        tick();
        #1;
        checks++; if (fwd_rs_sel !== 2'b00) begin errors++; $display("FAIL fwd_w_rf got=%b exp=00", fwd_rs_sel); end
        idle(); tick();
    endtask

    task automatic test_load_use();
        idle(); issue(5'd7, 1, 1, 0);
        tick();
        idle(); issue(5'd0, 0, 0, 0); query_rt = 5'd7;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b exp=1", stall); end
        tick();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%0b exp=0", stall); end
        checks++; if (fwd_rt_sel !== 2'b10) begin errors++; $display("FAIL lu_rt_mw got=%b exp=10", fwd_rt_sel); end
        idle(); tick(); tick();
    endtask

    task automatic test_long();
        idle(); issue(5'd9, 1, 0, 1);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL long_issue_stall got=%0b exp=0", stall); end
        tick();
        idle(); issue(5'd0, 0, 0, 0); query_rs = 5'd9;
        #1;
        checks++; if (long_busy !== 1'b1) begin errors++; $display("FAIL long_busy_set got=%0b exp=1", long_busy); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL long_raw_stall got=%0b exp=1", stall); end
        tick();
        wb_long_valid = 1; wb_long_rd = 5'd4;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL long_wrong_wb got=%0b exp=1", stall); end
        tick();
        wb_long_valid = 1; wb_long_rd = 5'd9;
        #1;
        checks++; if (long_busy !== 1'b1) begin errors++; $display("FAIL long_busy_hold got=%0b exp=1", long_busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL long_wb_stall got=%0b exp=0", stall); end
        checks++; if (fwd_rs_sel !== 2'b11) begin errors++; $display("FAIL long_wb_sel got=%b exp=11", fwd_rs_sel); end
        tick();
        idle();
        #1;
        checks++; if (long_busy !== 1'b0) begin errors++; $display("FAIL long_busy_clear got=%0b exp=0", long_busy); end
        tick();
    endtask

    task automatic test_back_to_back_long();
        idle(); issue(5'd9, 1, 0, 1);
        tick();
        idle(); issue(5'd4, 1, 0, 1);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_struct_stall got=%0b exp=1", stall); end
        idle(); issue(5'd3, 1, 0, 1); wb_long_valid = 1; wb_long_rd = 5'd9;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_swap_stall got=%0b exp=0", stall); end
        tick();
        idle(); issue(5'd0, 0, 0, 0); query_rs = 5'd9;
        #1;
        checks++; if (long_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%0b exp=1", long_busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_old_rd_free got=%0b exp=0", stall); end
        query_rs = 5'd3;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_new_rd_pending got=%0b exp=1", stall); end
        idle(); issue(5'd3, 1, 0, 0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_waw got=%0b exp=1", stall); end
        idle(); wb_long_valid = 1; wb_long_rd = 5'd3;
        tick();
        idle();
        #1;
        checks++; if (long_busy !== 1'b0) begin errors++; $display("FAIL b2b_final_clear got=%0b exp=0", long_busy); end
        tick();
    endtask

    task automatic test_r0();
        idle(); issue(5'd0, 1, 1, 0);
        tick();
        idle(); issue(5'd0, 0, 0, 0); query_rs = 5'd0; query_rt = 5'd0;
        wb_long_valid = 1; wb_long_rd = 5'd0;
        #1;
        checks++; if (fwd_rs_sel !== 2'b00) begin errors++; $display("FAIL r0_rs_sel got=%b exp=00", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== 2'b00) begin errors++; $display("FAIL r0_rt_sel got=%b exp=00", fwd_rt_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got=%0b exp=0", stall); end
        idle(); issue(5'd0, 1, 0, 1);
        tick();
        idle();
        #1;
        checks++; if (long_busy !== 1'b0) begin errors++; $display("FAIL r0_long got=%0b exp=0", long_busy); end
        tick();
    endtask

    task automatic test_reset_mid_long();
        idle(); issue(5'd9, 1, 0, 1);
        tick();
        idle(); issue(5'd6, 1, 0, 0);
        tick();
        idle(); issue(5'd0, 0, 0, 0); query_rs = 5'd6; query_rt = 5'd9;
        #1;
        checks++; if (fwd_rs_sel !== 2'b01) begin errors++; $display("FAIL rst_pre_sel got=%b exp=01", fwd_rs_sel); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got=%0b exp=1", stall); end
        reset_n = 0;
        #1;
        checks++; if (long_busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got=%0b exp=0", long_busy); end
        checks++; if (fwd_rs_sel !== 2'b00) begin errors++; $display("FAIL rst_async_rs got=%b exp=00", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== 2'b00) begin errors++; $display("FAIL rst_async_rt got=%b exp=00", fwd_rt_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_async_stall got=%0b exp=0", stall); end
        #1;
        reset_n = 1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_post_stall got=%0b exp=0", stall); end
        checks++; if (fwd_rs_sel !== 2'b00) begin errors++; $display("FAIL rst_post_rs got=%b exp=00", fwd_rs_sel); end
        idle(); tick();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_long();
        test_back_to_back_long();
        test_r0();
        test_reset_mid_long();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
